// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Pulled in by the interface, the selector and the top.
package fifo_wr_arbiter_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_DATA_W    = 128;
   localparam int DEF_BURST_LEN = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Successor of a requester index with an explicit wrap, so that
   // non-power-of-2 requester counts work.
   function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
      return (id == n - 1) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the arbiter.
// The FIFO side maps onto the FIFO write port as fifo_wren->i_wren, fifo_wrdata->i_wrdata, o_full->fifo_full.
interface fifo_wr_arbiter_if
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W
);
   localparam int IW = $clog2(NUM_REQ);

   logic                             arb_en;
   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0][DATA_W-1:0]   req_data;
   logic [NUM_REQ-1:0]               req_ready;
   logic                             fifo_full;
   logic                             fifo_wren;
   logic [DATA_W-1:0]                fifo_wrdata;
   logic                             grant_vld;
   logic [IW-1:0]                    grant_id;

   // Arbiter side.
   modport slave (
      input  arb_en, req_valid, req_data, fifo_full,
      output req_ready, fifo_wren, fifo_wrdata, grant_vld, grant_id
   );

   // Requesters plus FIFO side, as seen from outside the arbiter.
   modport master (
      output arb_en, req_valid, req_data, fifo_full,
      input  req_ready, fifo_wren, fifo_wrdata, grant_vld, grant_id
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Circular-priority selector: first set bit of valid at or after ptr.
// Pure combinational; the wrap past N-1 is done explicitly.
module rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   // Scan from the far end back toward ptr so the nearest candidate wins.
   always_comb begin : scan
      int c;
      found = 1'b0;
      idx   = '0;
      c     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         if (valid[IW'(c)]) begin
            found = 1'b1;
            idx   = IW'(c);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grant and state are registered; ready/wren/wrdata are combinational off the held grant.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input logic           clk,
   input logic           rstn,
   fifo_wr_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BURST_LEN) + 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN);

   arb_state_e    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant_id;
   logic          grant_vld;
   logic [CW-1:0] beat_cnt;

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] nxt_ptr;
   logic          gnt_valid;
   logic          xfer;
   logic          last_beat;
   logic [DATA_W-1:0] wr_data;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .valid (bus.req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign gnt_valid = bus.req_valid[grant_id];
   assign xfer      = grant_vld & gnt_valid & ~bus.fifo_full;
   assign last_beat = (beat_cnt + CW'(1)) == LAST_BEAT;
   assign nxt_ptr   = IW'(rr_next(int'(grant_id), NUM_REQ));

   // A burst always returns to IDLE for at least one cycle before the next grant.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         grant_vld <= 1'b0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.arb_en && pick_found) begin
                  state     <= BURST;
                  grant_id  <= pick_idx;
                  grant_vld <= 1'b1;
                  beat_cnt  <= '0;
               end
            end
            BURST: begin
               // arb_en is deliberately ignored here: a started burst runs to its end.
               if (!gnt_valid || (xfer && last_beat)) begin
                  state     <= IDLE;
                  grant_vld <= 1'b0;
                  grant_id  <= '0;
                  rr_ptr    <= nxt_ptr;
               end
               if (xfer) beat_cnt <= beat_cnt + CW'(1);
            end
            default: begin
               state     <= IDLE;
               grant_vld <= 1'b0;
               grant_id  <= '0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
      assign bus.req_ready[i] = grant_vld & (grant_id == IW'(i)) & ~bus.fifo_full;
   end

   assign wr_data         = bus.req_data[grant_id];
   assign bus.fifo_wren   = xfer;
   assign bus.fifo_wrdata = grant_vld ? wr_data : '0;
   assign bus.grant_vld   = grant_vld;
   assign bus.grant_id    = grant_id;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one FIFO write port (2..16).
REQ-002 Parameter DATA_W, default 128, write-data width; shall match the FIFO data width.
REQ-003 Parameter BURST_LEN, default 8, maximum beats per grant (1..256).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 arb_en  input  1  high permits new grants; low lets the current burst finish, then no new grants.
REQ-007 req_valid  input  NUM_REQ  per-requester data-valid.
REQ-008 req_data  input  NUM_REQ*DATA_W  per-requester write data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  output  NUM_REQ  per-requester accept; transfer when valid and ready are both high.
REQ-010 fifo_full  input  1  FIFO full flag.
REQ-011 fifo_wren  output  1  FIFO write enable.
REQ-012 fifo_wrdata  output  DATA_W  FIFO write data.
REQ-013 grant_vld  output  1  a grant is held.
REQ-014 grant_id  output  $clog2(NUM_REQ)  index of the granted requester; 0 when grant_vld is low.

Function
REQ-015 FSM shall have two states: IDLE and BURST.
REQ-016 IDLE: if arb_en is high and any req_valid is high, select the first valid requester at or after rr_ptr (circular search), register it as the grant, clear beat_cnt, and enter BURST on the next edge.
REQ-017 IDLE: req_ready, fifo_wren and grant_vld shall all be 0.
REQ-018 BURST: req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
REQ-019 fifo_wren = req_valid[grant_id] & req_ready[grant_id]; this path is combinational, with zero-cycle latency from handshake to FIFO write.
REQ-020 fifo_wrdata = req_data slice of grant_id; 0 in IDLE.
REQ-021 Each transfer shall increment beat_cnt, whose width is $clog2(BURST_LEN)+1 bits, so that no wrap occurs before the limit.
REQ-022 BURST shall exit to IDLE on the edge of the transfer that makes beat_cnt equal BURST_LEN.
REQ-023 BURST shall also exit to IDLE on any cycle where req_valid[grant_id] is 0.
REQ-024 While fifo_full is high and req_valid[grant_id] is high, the grant shall be held, with no exit and no count change.
REQ-025 On every BURST exit, rr_ptr = (grant_id + 1) mod NUM_REQ; the wrap from NUM_REQ-1 to 0 shall be explicit, and non-power-of-2 NUM_REQ shall be supported.
REQ-026 A new grant requires at least one IDLE cycle between bursts; back-to-back bursts without an IDLE cycle are not permitted.
REQ-027 arb_en deasserting during BURST shall not truncate the burst.
REQ-028 Requester data shall never be lost or duplicated: exactly one FIFO write per handshake.

Reset
REQ-029 On rstn low, asynchronously: state = IDLE, rr_ptr = 0, beat_cnt = 0, grant_id = 0, grant_vld = 0.
REQ-030 During reset, all req_ready bits, fifo_wren and fifo_wrdata shall be 0.
REQ-031 Reset asserted mid-burst shall abandon the burst; beats already written remain in the FIFO.

Structure
REQ-032 A shared package shall hold the FSM state enum (IDLE, BURST) and the default parameter constants.
REQ-033 The round-robin circular-priority selector (valid vector + start pointer -> found flag + index) shall be one sub-module, rr_pick.
REQ-034 The block shall connect directly to the team FIFO write port (i_wren, i_wrdata, o_full).

Verification
REQ-035 Scenario: NUM_REQ=4, BURST_LEN=8, all valid continuously, FIFO never full -> grants 0,1,2,3,0; each grant lasts 8 writes; one IDLE cycle between grants.
REQ-036 Scenario: only requester 2 valid, for 3 beats -> grant_id=2 for 3 writes, exit on valid drop, rr_ptr=3.
REQ-037 Scenario: fifo_full asserted for 5 cycles on beat 4 of a burst -> req_ready=0 and fifo_wren=0 for those 5 cycles, grant held, burst completes at 8 total writes.
REQ-038 Scenario: arb_en dropped on beat 2 with all requesters valid -> burst completes 8 beats, then the block stays in IDLE until arb_en returns.
REQ-039 Scenario: rstn pulsed low mid-burst at beat 5 -> outputs 0 immediately; after release, the first grant goes to requester 0.
REQ-040 Scenario: scoreboard -> every accepted requester word appears exactly once, in per-requester order, on fifo_wrdata.
